// File: rtl/tri_unpacker_pkg.sv
// Shared types and constants for the AHB triangle unpacker.
package tri_unpacker_pkg;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } Point3D;

    typedef struct packed {
        Point3D p;
        Point3D q;
        Point3D r;
    } Triangle3D;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } Color;

    typedef enum logic [1:0] {IDLE, RECV, DRAIN} UnpackState;

    localparam int          AHB_WORDS_PER_TRI = 6;
    localparam logic [31:0] FRAME_START_WORD  = 32'd0;
    localparam logic [31:0] FRAME_END_WORD    = 32'd1;

endpackage

// File: rtl/tri_unpacker_out.sv
// Output register for one assembled triangle; holds until downstream takes it.
module tri_unpacker_out
    import tri_unpacker_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  Triangle3D tri_in,
    input  Color      col_in,
    input  logic      tri_read,
    output Triangle3D triangle,
    output Color      color,
    output logic      tri_ready
);

    always_ff @(posedge clk) begin
        if (rst) begin
            triangle  <= '0;
            color     <= '0;
            tri_ready <= 1'b0;
        end else if (load) begin
            // a load in the same cycle as a take keeps tri_ready high with no gap
            triangle  <= tri_in;
            color     <= col_in;
            tri_ready <= 1'b1;
        end else if (tri_ready && tri_read) begin
            tri_ready <= 1'b0;
        end
    end

endmodule

// File: rtl/tri_unpacker.sv
// Frames the AHB word stream and rebuilds 6-word packets into triangles.
module tri_unpacker
    import tri_unpacker_pkg::*;
#(
    parameter logic [31:0] FRAME_START = FRAME_START_WORD,
    parameter logic [31:0] FRAME_END   = FRAME_END_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ahb_buffer,
    input  logic        ahb_data_available,
    output logic        ahb_user_read_buffer,
    output Triangle3D   triangle,
    output Color        color,
    output logic        tri_ready,
    input  logic        tri_read,
    output logic        frame_active,
    output logic        frame_done,
    output logic [7:0]  drop_count
);

    localparam logic [2:0] LAST_SLOT = 3'(AHB_WORDS_PER_TRI - 1);

    UnpackState state, state_d;
    logic [2:0] slot;
    Triangle3D  stg_tri;
    Color       stg_col, ld_col;
    logic       accept, load, word_in;

    assign word_in              = ahb_data_available && !rst;
    assign ahb_user_read_buffer = word_in && accept;

    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        load       = 1'b0;
        frame_done = 1'b0;
        ld_col     = stg_col;
        ld_col.b   = ahb_buffer[7:0];
        case (state)
            IDLE: begin
                accept = 1'b1;
                if (word_in && ahb_buffer == FRAME_START)
                    state_d = RECV;
            end
            RECV: begin
                // only the final word waits for the output register to free up
                accept = (slot != LAST_SLOT) || !(tri_ready && !tri_read);
                if (word_in && accept && slot == 3'd0 && ahb_buffer == FRAME_END)
                    state_d = DRAIN;
                load = word_in && accept && slot == LAST_SLOT;
            end
            DRAIN: begin
                if (!tri_ready) begin
                    frame_done = !rst;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot         <= 3'd0;
            stg_tri      <= '0;
            stg_col      <= '0;
            drop_count   <= 8'd0;
            frame_active <= 1'b0;
        end else begin
            if (state == DRAIN && state_d == IDLE)
                frame_active <= 1'b0;
            if (ahb_user_read_buffer) begin
                case (state)
                    IDLE: begin
                        if (ahb_buffer == FRAME_START)
                            frame_active <= 1'b1;
                        else if (drop_count != 8'hFF)
                            drop_count <= drop_count + 8'd1;
                    end
                    RECV: begin
                        if (!(slot == 3'd0 && ahb_buffer == FRAME_END)) begin
                            case (slot)
                                3'd0: begin
                                    stg_tri.p.x <= ahb_buffer[15:0];
                                    stg_tri.p.y <= ahb_buffer[31:16];
                                end
                                3'd1: begin
                                    stg_tri.p.z <= ahb_buffer[15:0];
                                    stg_tri.q.x <= ahb_buffer[31:16];
                                end
                                3'd2: begin
                                    stg_tri.q.y <= ahb_buffer[15:0];
                                    stg_tri.q.z <= ahb_buffer[31:16];
                                end
                                3'd3: begin
                                    stg_tri.r.x <= ahb_buffer[15:0];
                                    stg_tri.r.y <= ahb_buffer[31:16];
                                end
                                3'd4: begin
                                    stg_tri.r.z <= ahb_buffer[15:0];
                                    stg_col.r   <= ahb_buffer[23:16];
                                    stg_col.g   <= ahb_buffer[31:24];
                                end
                                default: stg_col.b <= ahb_buffer[7:0];
                            endcase
                            slot <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    tri_unpacker_out u_out (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .tri_in   (stg_tri),
        .col_in   (ld_col),
        .tri_read (tri_read),
        .triangle (triangle),
        .color    (color),
        .tri_ready(tri_ready)
    );

endmodule

// File: tb/tb_tri_unpacker.sv
// Randomised and directed checks of tri_unpacker against a word-queue reference model.
module tb_tri_unpacker;
    import tri_unpacker_pkg::*;

    typedef logic [31:0] pkt_t [6];

    logic        tb_clk = 1'b0;
    logic        rst, ahb_data_available, ahb_user_read_buffer;
    logic        tri_ready, tri_read, frame_active, frame_done;
    logic [31:0] ahb_buffer;
    logic [7:0]  drop_count;
    Triangle3D   triangle;
    Color        color;

    always #5 tb_clk = ~tb_clk;

    tri_unpacker dut (
        .clk                 (tb_clk),
        .rst                 (rst),
        .ahb_buffer          (ahb_buffer),
        .ahb_data_available  (ahb_data_available),
        .ahb_user_read_buffer(ahb_user_read_buffer),
        .triangle            (triangle),
        .color               (color),
        .tri_ready           (tri_ready),
        .tri_read            (tri_read),
        .frame_active        (frame_active),
        .frame_done          (frame_done),
        .drop_count          (drop_count)
    );

    int total = 0;
    int bad   = 0;
    int hs    = 0;
    int dn    = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: frame mode, words of the packet in flight, words of the presented triangle
    int          m_mode;   // 0 idle, 1 receiving, 2 draining
    logic [31:0] m_pkt[$];
    pkt_t        m_out;
    bit          m_ready, m_active, m_on;
    int          m_drop;

    function automatic Triangle3D dec_tri(input pkt_t w);
        Triangle3D t;
        t.p.x = w[0][15:0];  t.p.y = w[0][31:16];
        t.p.z = w[1][15:0];  t.q.x = w[1][31:16];
        t.q.y = w[2][15:0];  t.q.z = w[2][31:16];
        t.r.x = w[3][15:0];  t.r.y = w[3][31:16];
        t.r.z = w[4][15:0];
        return t;
    endfunction

    function automatic Color dec_col(input pkt_t w);
        Color c;
        c.r = w[4][23:16];
        c.g = w[4][31:24];
        c.b = w[5][7:0];
        return c;
    endfunction

    function automatic bit exp_rd();
        if (rst || !ahb_data_available) return 1'b0;
        if (m_mode == 0) return 1'b1;
        if (m_mode == 1) return (m_pkt.size() < 5) || !(m_ready && !tri_read);
        return 1'b0;
    endfunction

    initial m_on = 1'b0;

    always @(posedge tb_clk) begin : model
        bit rd, ld;
        rd = exp_rd();
        ld = 1'b0;
        if (rst) begin
            m_mode = 0; m_pkt.delete(); m_ready = 0; m_active = 0; m_drop = 0; m_on = 1;
            foreach (m_out[i]) m_out[i] = 32'd0;
        end else begin
            if (m_mode == 2 && !m_ready) begin
                m_mode = 0; m_active = 0;
            end else if (rd) begin
                if (m_mode == 0) begin
                    if (ahb_buffer == 32'd0) begin m_mode = 1; m_active = 1; end
                    else if (m_drop < 255) m_drop++;
                end else if (m_pkt.size() == 0 && ahb_buffer == 32'd1) begin
                    m_mode = 2;
                end else begin
                    m_pkt.push_back(ahb_buffer);
                    if (m_pkt.size() == 6) begin
                        foreach (m_out[i]) m_out[i] = m_pkt[i];
                        m_pkt.delete();
                        ld = 1'b1;
                    end
                end
            end
            if (ld) m_ready = 1;
            else if (m_ready && tri_read) m_ready = 0;
        end
    end

    always @(negedge tb_clk) begin
        if (m_on) begin
            check("read_buffer", 192'(ahb_user_read_buffer), 192'(exp_rd()));
            check("tri_ready", 192'(tri_ready), 192'(m_ready));
            check("frame_active", 192'(frame_active), 192'(m_active));
            check("frame_done", 192'(frame_done), 192'(!rst && m_mode == 2 && !m_ready));
            check("drop_count", 192'(drop_count), 192'(m_drop));
            check("triangle", 192'(triangle), 192'(dec_tri(m_out)));
            check("color", 192'(color), 192'(dec_col(m_out)));
            if (!rst && tri_ready && tri_read) hs++;
            if (frame_done) dn++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge tb_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic rd);
        bit c;
        ahb_buffer = w; ahb_data_available = 1'b1; tri_read = rd; c = 1'b0;
        for (int k = 0; k < 50 && !c; k++) begin
            @(negedge tb_clk);
            c = ahb_user_read_buffer;
            cyc(1);
        end
        check("word_consumed", 192'(c), 192'(1));
        ahb_data_available = 1'b0;
    endtask

    task automatic send_pkt(input pkt_t p, input logic rd);
        for (int i = 0; i < 6; i++) send(p[i], rd);
    endtask

    function automatic pkt_t rand_pkt();
        pkt_t p;
        foreach (p[i]) p[i] = $urandom;
        if (p[0] == 32'd1) p[0] = 32'd2;
        return p;
    endfunction

    initial begin
        pkt_t p1, p2;
        rst = 1'b1; ahb_data_available = 1'b0; tri_read = 1'b0; ahb_buffer = 32'd0;
        cyc(2);
        rst = 1'b0;
        check("reset_tri_ready", 192'(tri_ready), 192'(0));
        check("reset_drop", 192'(drop_count), 192'(0));

        // dropped words, then frame start
        send(32'h5, 1'b0);
        send(32'h7, 1'b0);
        send(32'h0, 1'b0);
        check("drop_two", 192'(drop_count), 192'(2));
        check("active_after_start", 192'(frame_active), 192'(1));

        // hand-built triangle, bits [31:8] of word 5 must be ignored
        p1 = '{32'h00BE_00A0, {16'd40, 16'd50}, {16'd30, 16'd239},
               {16'd239, 16'd280}, {8'd0, 8'd255, 16'd30}, 32'hABCD_EF00};
        send_pkt(p1, 1'b0);
        check("p1_ready", 192'(tri_ready), 192'(1));
        check("p1_px", 192'(triangle.p.x), 192'(160));
        check("p1_py", 192'(triangle.p.y), 192'(190));
        check("p1_pz", 192'(triangle.p.z), 192'(50));
        check("p1_q", 192'({triangle.q.x, triangle.q.y, triangle.q.z}), 192'({16'd40, 16'd239, 16'd30}));
        check("p1_r", 192'({triangle.r.x, triangle.r.y, triangle.r.z}), 192'({16'd280, 16'd239, 16'd30}));
        check("p1_color", 192'(color), 192'({8'd255, 8'd0, 8'd0}));

        // second packet while first is untaken: word 5 stalls until tri_read
        p2 = rand_pkt();
        for (int i = 0; i < 5; i++) send(p2[i], 1'b0);
        ahb_buffer = p2[5]; ahb_data_available = 1'b1; tri_read = 1'b0;
        @(negedge tb_clk);
        check("w5_stall", 192'(ahb_user_read_buffer), 192'(0));
        cyc(1);
        tri_read = 1'b1;
        @(negedge tb_clk);
        check("w5_with_read", 192'(ahb_user_read_buffer), 192'(1));
        cyc(1);
        ahb_data_available = 1'b0; tri_read = 1'b0;
        check("p2_no_gap", 192'(tri_ready), 192'(1));
        check("p2_tri", 192'(triangle), 192'(dec_tri(p2)));
        tri_read = 1'b1; cyc(1); tri_read = 1'b0;

        // 8 back-to-back triangles with tri_read held, then frame end
        hs = 0; dn = 0;
        for (int i = 0; i < 8; i++) send_pkt(rand_pkt(), 1'b1);
        send(32'd1, 1'b1);
        cyc(4);
        check("hs_eight", 192'(hs), 192'(8));
        check("done_once", 192'(dn), 192'(1));
        check("inactive_after_end", 192'(frame_active), 192'(0));
        tri_read = 1'b0;

        // frame end with a pending triangle: frame_done only after the take
        send(32'd0, 1'b0);
        send_pkt(rand_pkt(), 1'b0);
        send(32'd1, 1'b0);
        dn = 0;
        cyc(4);
        check("done_not_early", 192'(dn), 192'(0));
        tri_read = 1'b1; cyc(1); tri_read = 1'b0;
        @(negedge tb_clk);
        check("done_after_take", 192'(frame_done), 192'(1));
        cyc(1);
        check("inactive_after_drain", 192'(frame_active), 192'(0));

        // reset mid-packet
        send(32'd0, 1'b0);
        p2 = rand_pkt();
        for (int i = 0; i < 4; i++) send(p2[i], 1'b0);
        rst = 1'b1; cyc(1); rst = 1'b0;
        check("rst_outputs", 192'({tri_ready, frame_active, frame_done, drop_count}), 192'(0));
        check("rst_triangle", 192'({triangle, color}), 192'(0));
        send(32'd0, 1'b0);
        p2 = rand_pkt();
        send_pkt(p2, 1'b0);
        check("post_rst_tri", 192'(triangle), 192'(dec_tri(p2)));
        check("post_rst_col", 192'(color), 192'(dec_col(p2)));

        // randomised traffic
        for (int n = 0; n < 4000; n++) begin
            int r;
            rst = ($urandom_range(0, 599) == 0);
            ahb_data_available = ($urandom_range(0, 3) != 0);
            tri_read = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            ahb_buffer = (r == 0) ? 32'd0 : (r == 1) ? 32'd1 : $urandom;
            cyc(1);
        end
        rst = 1'b0; ahb_data_available = 1'b0; tri_read = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
